// File: rtl/amiq_sock_arb_pkg.sv
// Shared types and helpers for the socket transmit arbiter and the
// receive-side dispatcher.
package amiq_sock_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_DRAIN} arb_state_t;

   localparam int STAT_W = 16;

   // First set bit of valid at or after ptr, wrapping modulo n (n <= 16).
   // Returns ptr when nothing is valid; callers qualify with an any-valid flag.
   function automatic int unsigned rr_pick(input logic [15:0] valid,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned idx;
      int unsigned cand;
      logic        found;
      idx   = ptr;
      found = 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
         cand = ptr + k;
         if (cand >= n) cand = cand - n;
         if (!found && (k < n) && valid[cand[3:0]]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/amiq_rr_picker.sv
// Combinational round-robin priority search over N request lines (N <= 16).
module amiq_rr_picker
   import amiq_sock_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          valid_i,
   input  logic [$clog2(N)-1:0]  ptr_i,
   output logic                  any_o,
   output logic [$clog2(N)-1:0]  idx_o
);

   localparam int IW = $clog2(N);

   int unsigned pick;

   always_comb begin
      pick  = rr_pick(16'(valid_i), 32'(ptr_i), N);
      idx_o = IW'(pick);
      any_o = |valid_i;
   end

endmodule

// File: rtl/amiq_sock_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the outbound socket bridge.
// Define AMIQ_SOCK_ARB_STATS_EN to add per-requester packet and drop counters.
module amiq_sock_tx_arbiter
   import amiq_sock_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int MAX_LEN     = 256,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_done_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
   input  logic [NUM_REQ-1:0]           req_last_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic                         tx_valid_o,
   output logic [DATA_W-1:0]            tx_data_o,
   output logic                         tx_last_o,
   output logic [$clog2(NUM_REQ)-1:0]   tx_src_o,
   input  logic                         tx_ready_i,
   output logic                         busy_o,
   output logic                         timeout_err_o,
   output logic                         len_err_o,
`ifdef AMIQ_SOCK_ARB_STATS_EN
   output logic [NUM_REQ*STAT_W-1:0]    pkt_cnt_o,
   output logic [STAT_W-1:0]            drop_cnt_o,
`endif
   output logic [$clog2(NUM_REQ)-1:0]   err_src_o
);

   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int BEAT_W  = $clog2(MAX_LEN + 1);
   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [IDX_W-1:0]    err_src_q, err_src_d;

   logic                pick_any;
   logic [IDX_W-1:0]    pick_idx;
   logic                sel_valid;
   logic                sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic                len_hit;
   logic                hs;
   logic [IDX_W-1:0]    rr_next;

   amiq_rr_picker #(.N(NUM_REQ)) u_picker (
      .valid_i (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .any_o   (pick_any),
      .idx_o   (pick_idx)
   );

   assign sel_valid = req_valid_i[grant_q];
   assign sel_last  = req_last_i[grant_q];
   assign sel_data  = req_data_i[grant_q*DATA_W +: DATA_W];
   assign len_hit   = (beat_cnt_q == BEAT_W'(MAX_LEN - 1));
   assign hs        = (state_q == ARB_XFER) && sel_valid && tx_ready_i;
   assign rr_next   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
   assign busy_o    = (state_q != ARB_IDLE);
   assign err_src_o = err_src_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_src_q   <= err_src_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = grant_q;
      beat_cnt_d    = beat_cnt_q;
      stall_cnt_d   = stall_cnt_q;
      err_src_d     = err_src_q;
      tx_valid_o    = 1'b0;
      tx_data_o     = '0;
      tx_last_o     = 1'b0;
      tx_src_o      = '0;
      req_ready_o   = '0;
      timeout_err_o = 1'b0;
      len_err_o     = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
            if (cfg_done_i && pick_any) begin
               grant_d = pick_idx;
               state_d = ARB_XFER;
            end
         end
         ARB_XFER: begin
            tx_valid_o           = sel_valid;
            tx_data_o            = sel_data;
            tx_last_o            = sel_last | len_hit;
            tx_src_o             = grant_q;
            req_ready_o[grant_q] = tx_ready_i;
            if (hs) begin
               beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
               stall_cnt_d = '0;
               if (sel_last) begin
                  state_d    = ARB_IDLE;
                  rr_ptr_d   = rr_next;
                  beat_cnt_d = '0;
               end else if (len_hit) begin
                  // Bridge already saw a forced tx_last; swallow the tail.
                  len_err_o = 1'b1;
                  err_src_d = grant_q;
                  state_d   = ARB_DRAIN;
               end
            end else if (stall_cnt_q == STALL_W'(TIMEOUT_CYC - 1)) begin
               timeout_err_o = 1'b1;
               err_src_d     = grant_q;
               state_d       = ARB_DRAIN;
            end else begin
               stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
         end
         ARB_DRAIN: begin
            tx_src_o             = grant_q;
            req_ready_o[grant_q] = 1'b1;
            if (sel_valid && sel_last) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = rr_next;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

`ifdef AMIQ_SOCK_ARB_STATS_EN
   logic              pkt_done;
   logic [STAT_W-1:0] drop_cnt_q;

   assign pkt_done   = hs && sel_last;
   assign drop_cnt_o = drop_cnt_q;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pkt_cnt
      logic [STAT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (pkt_done && (grant_q == IDX_W'(gi)) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + STAT_W'(1);
         end
      end
      assign pkt_cnt_o[gi*STAT_W +: STAT_W] = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else if ((timeout_err_o || len_err_o) && (drop_cnt_q != '1)) begin
         drop_cnt_q <= drop_cnt_q + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_amiq_sock_tx_arbiter.sv
// Directed bench for amiq_sock_tx_arbiter (NUM_REQ=4, MAX_LEN=4, TIMEOUT_CYC=8).
module tb_amiq_sock_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cfg_done;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic [1:0]  tx_src;
   logic        tx_ready;
   logic        busy;
   logic        timeout_err;
   logic        len_err;
   logic [1:0]  err_src;
`ifdef AMIQ_SOCK_ARB_STATS_EN
   logic [63:0] pkt_cnt;
   logic [15:0] drop_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Producer state: packet length, current beat, active, restart-after-last.
   logic [3:0] act;
   logic [3:0] loop_en;
   int         plen [4];
   int         bcnt [4];

   amiq_sock_tx_arbiter #(
      .NUM_REQ     (4),
      .DATA_W      (8),
      .MAX_LEN     (4),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_done_i    (cfg_done),
      .req_valid_i   (req_valid),
      .req_data_i    (req_data),
      .req_last_i    (req_last),
      .req_ready_o   (req_ready),
      .tx_valid_o    (tx_valid),
      .tx_data_o     (tx_data),
      .tx_last_o     (tx_last),
      .tx_src_o      (tx_src),
      .tx_ready_i    (tx_ready),
      .busy_o        (busy),
      .timeout_err_o (timeout_err),
      .len_err_o     (len_err),
`ifdef AMIQ_SOCK_ARB_STATS_EN
      .pkt_cnt_o     (pkt_cnt),
      .drop_cnt_o    (drop_cnt),
`endif
      .err_src_o     (err_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]        = act[i];
         req_last[i]         = act[i] && (bcnt[i] == plen[i] - 1);
         req_data[i*8 +: 8]  = 8'(i * 16 + bcnt[i]);
      end
   endtask

   task automatic settle();
      drive_reqs();
      #1;
   endtask

   task automatic start(input int i, input int len);
      act[i]  = 1'b1;
      plen[i] = len;
      bcnt[i] = 0;
   endtask

   // Close the current cycle: record handshakes, clock once, update producers.
   task automatic advance();
      logic [3:0] hs;
      hs = req_ready & req_valid;
      if (tx_valid && tx_ready && tx_last)
         $display("[TB] packet end src=%0d data=0x%02h", tx_src, tx_data);
      if (timeout_err) $display("[TB] timeout abort src=%0d", tx_src);
      if (len_err)     $display("[TB] length truncation src=%0d", tx_src);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (hs[i]) begin
            if (bcnt[i] == plen[i] - 1) begin
               bcnt[i] = 0;
               if (!loop_en[i]) act[i] = 1'b0;
            end else begin
               bcnt[i] = bcnt[i] + 1;
            end
         end
      end
      settle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      act   = '0;
      for (int i = 0; i < 4; i++) bcnt[i] = 0;
      @(posedge clk);
      #1;
      settle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic       acc_v;
      logic       acc_b;
      logic [3:0] acc_r;
      int         pulses;
      int         ph;
      int         pk;
      int         src;

      rst_n    = 1'b0;
      cfg_done = 1'b0;
      tx_ready = 1'b0;
      act      = '0;
      loop_en  = '0;
      for (int i = 0; i < 4; i++) begin
         plen[i] = 1;
         bcnt[i] = 0;
      end
      drive_reqs();
      #3;
      check("rst_txv",  tx_valid, 0);
      check("rst_rdy",  req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_src",  tx_src, 0);
      check("rst_last", tx_last, 0);
      check("rst_errs", {timeout_err, len_err}, 0);
      check("rst_esrc", err_src, 0);
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // cfg_done gating
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) start(i, 1);
      settle();
      acc_v = 1'b0; acc_b = 1'b0; acc_r = '0;
      repeat (20) begin
         acc_v |= tx_valid;
         acc_b |= busy;
         acc_r |= req_ready;
         advance();
      end
      check("gate_txv",  acc_v, 0);
      check("gate_rdy",  acc_r, 0);
      check("gate_busy", acc_b, 0);
      cfg_done = 1'b1;
      settle();
      check("gate_idle_txv", tx_valid, 0);
      advance();
      check("gate_src",  tx_src, 0);
      check("gate_txv1", tx_valid, 1);
      check("gate_rdy1", req_ready, 4'b0001);
      check("gate_last", tx_last, 1);
      advance();
      act = '0;
      settle();
      check("gate_done_busy", busy, 0);
      do_reset();

      // round-robin: requesters 0 and 2, 3-beat packets back to back
      start(0, 3);
      start(2, 3);
      loop_en = 4'b0101;
      settle();
      for (int c = 0; c < 16; c++) begin
         ph  = c % 4;
         pk  = c / 4;
         src = (pk % 2 == 1) ? 2 : 0;
         check("rr_txv", 32'(ph != 0), tx_valid == 1'b1 ? 32'd1 : 32'd0);
         check("rr_rdy", req_ready, (ph != 0) ? (32'd1 << src) : 32'd0);
         if (ph != 0) begin
            check("rr_src",  tx_src, src);
            check("rr_data", tx_data, src * 16 + ph - 1);
            check("rr_last", tx_last, 32'(ph == 3));
         end
         advance();
      end
      loop_en = '0;
      act     = '0;

      // stall timeout on requester 1, then requester 2 is served
      start(1, 4);
      start(2, 1);
      settle();
      check("to_idle_txv",  tx_valid, 0);
      check("to_idle_busy", busy, 0);
      advance();
      check("to_src",  tx_src, 1);
      check("to_txv",  tx_valid, 1);
      check("to_data", tx_data, 8'h10);
      advance();
      tx_ready = 1'b0;
      settle();
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         check("to_pulse", timeout_err, 32'(k == 7));
         pulses += int'(timeout_err);
         if (k == 0) check("to_stall_rdy", req_ready, 0);
         advance();
      end
      tx_ready = 1'b1;
      settle();
      check("to_pulse_cnt",  pulses, 1);
      check("to_pulse_off",  timeout_err, 0);
      check("to_err_src",    err_src, 1);
      check("to_drain_txv",  tx_valid, 0);
      check("to_drain_rdy",  req_ready, 4'b0010);
      check("to_drain_busy", busy, 1);
      advance();
      check("to_drain_txv2", tx_valid, 0);
      advance();
      check("to_drain_txv3", tx_valid, 0);
      advance();
      check("to_post_busy", busy, 0);
      advance();
      check("to_next_src",  tx_src, 2);
      check("to_next_txv",  tx_valid, 1);
      check("to_next_last", tx_last, 1);
      advance();

      // truncation of a 6-beat packet from requester 3
      start(3, 6);
      settle();
      check("tr_idle_txv", tx_valid, 0);
      advance();
      for (int k = 0; k < 4; k++) begin
         check("tr_src",  tx_src, 3);
         check("tr_txv",  tx_valid, 1);
         check("tr_data", tx_data, 8'h30 + k);
         check("tr_last", tx_last, 32'(k == 3));
         check("tr_len",  len_err, 32'(k == 3));
         advance();
      end
      check("tr_drain_txv", tx_valid, 0);
      check("tr_drain_rdy", req_ready, 4'b1000);
      check("tr_err_src",   err_src, 3);
      check("tr_len_off",   len_err, 0);
      advance();
      check("tr_drain_txv2", tx_valid, 0);
      advance();
      start(1, 1);
      start(3, 1);
      settle();
      check("tr_idle2_txv", tx_valid, 0);
      advance();
      check("tr_ptr_wrap", tx_src, 1);
      advance();
      act[3] = 1'b0;

      // asynchronous reset in the middle of a packet
      start(1, 5);
      settle();
      advance();
      check("rs_src", tx_src, 1);
      advance();
      advance();
      check("rs_b2", tx_data, 8'h12);
      rst_n = 1'b0;
      #1;
      check("rs_txv",  tx_valid, 0);
      check("rs_rdy",  req_ready, 0);
      check("rs_busy", busy, 0);
      check("rs_src0", tx_src, 0);
      check("rs_last", tx_last, 0);
      check("rs_esrc", err_src, 0);
      check("rs_errs", {timeout_err, len_err}, 0);
      act   = '0;
      rst_n = 1'b1;
      #1;
      start(0, 1);
      start(3, 1);
      settle();
      check("rs_idle_txv", tx_valid, 0);
      advance();
      check("rs_restart_src", tx_src, 0);
      check("rs_restart_txv", tx_valid, 1);
      advance();
      advance();
      check("rs_second_src", tx_src, 3);
      advance();

`ifdef AMIQ_SOCK_ARB_STATS_EN
      // three good packets from requester 2, then one timeout
      for (int p = 0; p < 3; p++) begin
         start(2, 1);
         settle();
         advance();
         advance();
      end
      start(2, 2);
      tx_ready = 1'b0;
      settle();
      advance();
      repeat (10) advance();
      tx_ready = 1'b1;
      settle();
      check("st_pkt2",  pkt_cnt[32 +: 16], 3);
      check("st_pkt0",  pkt_cnt[0 +: 16], 1);
      check("st_drop",  drop_cnt, 1);
      check("st_idle",  busy, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/amiq_sock_tx_arbiter.md
Name: amiq_sock_tx_arbiter

Overview:
- Shares the single outbound socket channel among NUM_REQ independent RTL message producers.
- Arbitrates round-robin at packet granularity and holds the grant until the packet's last beat.
- Enforces a per-packet stall timeout and a maximum packet length.
- Sits between the producers and the DPI send bridge, which collects tx beats into a buffer and calls send_data on tx_last.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_W, 8: beat width in bits (one byte per beat to the bridge).
- MAX_LEN, 256: maximum beats per packet, >=2.
- TIMEOUT_CYC, 1024: consecutive stalled cycles inside a granted packet before it is aborted, >=2.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cfg_done  in  1  socket configured; no new grant while low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_ready  out  NUM_REQ  per-requester beat accept
- tx_valid  out  1  beat valid to the bridge
- tx_data  out  DATA_W  beat data
- tx_last  out  1  last beat (may be forced)
- tx_src  out  $clog2(NUM_REQ)  index of the granted requester
- tx_ready  in  1  bridge accept
- busy  out  1  a packet is in progress (XFER or DRAIN)
- timeout_err  out  1  one-cycle pulse on timeout abort
- len_err  out  1  one-cycle pulse on forced truncation
- err_src  out  $clog2(NUM_REQ)  requester that caused the last error; holds until the next error

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0.
  - beat_cnt, stall_cnt, grant = 0.
  - All outputs 0.
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - If cfg_done=1 and any req_valid, grant = first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Grant is registered; go to XFER.
  - Nothing is accepted in IDLE, so the first beat reaches tx one cycle after the request is seen.
- XFER:
  - tx_valid=req_valid[grant], tx_data=req_data[grant], tx_src=grant, req_ready[grant]=tx_ready. All other req_ready=0.
  - tx_data is don't-care when tx_valid=0.
  - tx_last=req_last[grant], OR'ed with (beat_cnt==MAX_LEN-1).
  - Each handshake (tx_valid & tx_ready) increments beat_cnt and clears stall_cnt.
  - Every other cycle increments stall_cnt; this covers both requester starvation and bridge backpressure.
  - Handshake with req_last=1: return to IDLE, rr_ptr=(grant+1) mod NUM_REQ, beat_cnt=0.
  - Handshake at beat_cnt==MAX_LEN-1 with req_last=0 (forced tx_last): pulse len_err, err_src=grant, go to DRAIN.
  - stall_cnt reaching TIMEOUT_CYC-1 with no handshake that cycle: pulse timeout_err, err_src=grant, go to DRAIN. tx_last is never emitted for that packet; the bridge discards its partial buffer on timeout_err.
  - If timeout and handshake coincide, the handshake wins and the counter clears.
- DRAIN:
  - tx_valid=0, req_ready[grant]=1. Beats are discarded until req_valid & req_last.
  - Then go to IDLE and advance rr_ptr as in XFER.
  - No timeout applies in DRAIN.
- cfg_done falling mid-packet has no effect on the current packet; it only blocks the next grant.
- Async reset mid-packet abandons the packet with no error pulse.
- busy=1 in XFER and DRAIN.
- Counter widths: beat_cnt is $clog2(MAX_LEN+1) bits and stall_cnt is $clog2(TIMEOUT_CYC+1) bits; neither wraps.

Optional Feature:
- Macro: AMIQ_SOCK_ARB_STATS_EN.
- When defined:
  - Adds output pkt_cnt (NUM_REQ*16 bits): per-requester count of packets completed via XFER, saturating at 16'hFFFF.
  - Adds output drop_cnt (16 bits): total timeout plus len_err events, saturating.
  - Both reset to 0.
- When undefined: those ports and their counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package amiq_sock_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_DRAIN} arb_state_t
  - localparam STAT_W=16
  - function rr_pick(valid vector, ptr) returning the index
- One sub-module is natural: amiq_rr_picker, a combinational round-robin priority search, reusable by the receive-side dispatcher.

Test Plan:
- Round-robin: NUM_REQ=4, requesters 0 and 2 each send 3-beat packets continuously with tx_ready=1. tx_src must alternate 0,2,0,2 with no interleaving of beats inside a packet. There is one idle cycle between packets.
- Gating: cfg_done=0 with req_valid=4'b1111 for 20 cycles gives tx_valid=0 and req_ready=0. Raising cfg_done gives grant=0 on the next cycle.
- Backpressure and timeout: TIMEOUT_CYC=8; requester 1 sends beat 0, then tx_ready=0 for 8 cycles. timeout_err pulses exactly once at the 8th stalled cycle with err_src=1. Remaining beats are drained with tx_valid=0, then the next requester is granted.
- Truncation: MAX_LEN=4; requester 3 sends a 6-beat packet. tx shows 4 beats, tx_last on the 4th, len_err pulses, beats 5–6 are dropped, and rr_ptr becomes 0.
- Reset mid-packet: assert rst_n=0 during beat 2 of a 5-beat packet. All outputs go to 0 immediately. After release, arbitration restarts from requester 0.
- Stats (AMIQ_SOCK_ARB_STATS_EN defined): 3 good packets from requester 2 plus 1 timeout give pkt_cnt[2]=3 and drop_cnt=1.
